// File: rtl/result_drain.sv
// Streams 4x4 result tiles out of the output bank over valid/ready.
// A 2-entry buffer plus a credit count hides the bank's one-cycle read latency.
module result_drain #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int TILE_WORDS = 16,
    parameter int BASE_ADDR  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        num_tiles,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic [7:0]        m_tile
);
    localparam int WW = $clog2(TILE_WORDS + 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
    state_t state, nextState;

    logic [7:0]        numTilesQ, tileCnt;
    logic [WW-1:0]     wordCnt;
    logic              rdVld_p1, rdLast_p1;
    logic [7:0]        rdTile_p1;
    logic [DATA_W-1:0] bufData [2];
    logic              bufLast [2];
    logic [7:0]        bufTile [2];
    logic              rdPtr, wrPtr;
    logic [1:0]        count;
    logic              zeroDone, flushDone, rdEn, lastRead, accept;
    logic              pop, popBuf, push, headFromBuf;
    logic [2:0]        credUse;
    logic [ADDR_W-1:0] rdAddr;

    // With the buffer empty, returning read data goes straight to the stream port.
    assign headFromBuf = (count != 2'd0) || !rdVld_p1;
    assign m_valid     = (count != 2'd0) || rdVld_p1;
    assign m_data      = headFromBuf ? bufData[rdPtr] : mem_rdata;
    assign m_last      = headFromBuf ? bufLast[rdPtr] : rdLast_p1;
    assign m_tile      = headFromBuf ? bufTile[rdPtr] : rdTile_p1;

    assign pop    = m_valid && m_ready;
    assign popBuf = pop && (count != 2'd0);
    assign push   = rdVld_p1 && !(pop && (count == 2'd0));

    // Slots still claimed after this cycle's pop; a new read needs one free.
    assign credUse  = {1'b0, count} + {2'b0, rdVld_p1} - {2'b0, pop};
    assign lastRead = (wordCnt == WW'(TILE_WORDS - 1)) && (tileCnt == numTilesQ - 8'd1);
    assign rdAddr   = ADDR_W'(BASE_ADDR) + ADDR_W'(tileCnt) * ADDR_W'(TILE_WORDS)
                    + ADDR_W'(wordCnt);
    assign accept   = (state == IDLE) && start;

    assign mem_rd_en = rdEn;
    assign mem_addr  = rdEn ? rdAddr : '0;
    assign busy      = (state != IDLE);
    assign done      = flushDone || zeroDone;

    always_comb begin
        nextState = state;
        rdEn      = 1'b0;
        flushDone = 1'b0;
        case (state)
            IDLE: begin
                if (start && (num_tiles != 8'd0)) nextState = RUN;
            end
            RUN: begin
                rdEn = (credUse < 3'd2);
                if (rdEn && lastRead) nextState = FLUSH;
            end
            FLUSH: begin
                if ((count == 2'd0) && !rdVld_p1) begin
                    flushDone = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Issue stage: state, address counters and tile count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            numTilesQ <= '0;
            tileCnt   <= '0;
            wordCnt   <= '0;
            zeroDone  <= 1'b0;
        end else begin
            state    <= nextState;
            zeroDone <= accept && (num_tiles == 8'd0);
            if (accept) begin
                numTilesQ <= num_tiles;
                tileCnt   <= '0;
                wordCnt   <= '0;
            end else if (rdEn) begin
                if (wordCnt == WW'(TILE_WORDS - 1)) begin
                    wordCnt <= '0;
                    tileCnt <= tileCnt + 8'd1;
                end else begin
                    wordCnt <= wordCnt + WW'(1);
                end
            end
        end
    end

    // Return stage: in-flight read tag and the 2-entry buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdVld_p1  <= 1'b0;
            rdLast_p1 <= 1'b0;
            rdTile_p1 <= '0;
            rdPtr     <= 1'b0;
            wrPtr     <= 1'b0;
            count     <= '0;
            for (int i = 0; i < 2; i++) begin
                bufData[i] <= '0;
                bufLast[i] <= 1'b0;
                bufTile[i] <= '0;
            end
        end else begin
            rdVld_p1  <= rdEn;
            rdLast_p1 <= (wordCnt == WW'(TILE_WORDS - 1));
            rdTile_p1 <= tileCnt;
            if (push) begin
                bufData[wrPtr] <= mem_rdata;
                bufLast[wrPtr] <= rdLast_p1;
                bufTile[wrPtr] <= rdTile_p1;
                wrPtr          <= ~wrPtr;
            end
            if (popBuf) rdPtr <= ~rdPtr;
            count <= count + {1'b0, push} - {1'b0, popBuf};
        end
    end
endmodule
